// File: rtl/modulo_contador_regressivo.sv
// modulo_contador_regressivo: two-digit BCD countdown timer with load/start/pause and a one-cycle done pulse
// Ports: clock (falling-edge), clear (async active-low), load/load_value (clamped BCD preset),
//        start, pause, tick (count strobe); count_bcd, zero, busy, done (one-cycle pulse at 00)
module modulo_contador_regressivo #(
    parameter logic [7:0] INIT_VALUE = 8'h30
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [7:0] count_bcd,
    output logic       zero,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
    state_t     state;
    logic [7:0] reload;
    logic [7:0] clamped;
    logic [7:0] decremented;
    logic       go;
    assign clamped     = {(load_value[7:4] > 4'd9) ? 4'd9 : load_value[7:4],
                          (load_value[3:0] > 4'd9) ? 4'd9 : load_value[3:0]};
    // units borrow from tens; never used at 00 since the decrement is gated on nonzero
    assign decremented = (count_bcd[3:0] == 4'd0) ? {count_bcd[7:4] - 4'd1, 4'd9} : count_bcd - 8'd1;
    // pause outranks start in every state
    assign go          = start && !pause;
    assign zero        = (count_bcd == 8'h00);
    assign busy        = (state == RUNNING) || (state == PAUSED);
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            count_bcd <= INIT_VALUE;
            reload    <= INIT_VALUE;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count_bcd <= clamped;
                reload    <= clamped;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        state <= zero ? DONE : RUNNING;
                        done  <= zero;
                    end
                    RUNNING: if (pause) begin
                        state <= PAUSED;
                    end else if (tick && !zero) begin
                        count_bcd <= decremented;
                        if (count_bcd == 8'h01) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    PAUSED: if (go) state <= RUNNING;
                    DONE: if (go) begin
                        count_bcd <= reload;
                        state     <= RUNNING;
                    end
                endcase
            end
        end
    end
endmodule
